fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8, program counter and instruction-address width.
REQ-002 Parameter INSTR_WIDTH, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 br_valid  input  1  execute stage has resolved a control-flow instruction this cycle.
REQ-008 pc_sel  input  1  branch-decision output; 1 = taken, qualified by br_valid.
REQ-009 br_target  input  PC_WIDTH  redirect address, valid when br_valid.
REQ-010 imem_req  output  1  instruction-memory read request.
REQ-011 imem_addr  output  PC_WIDTH  read address, equals pc.
REQ-012 imem_gnt  input  1  memory accepted request; imem_rdata valid same cycle.
REQ-013 imem_rdata  input  INSTR_WIDTH  instruction word.
REQ-014 instr_valid  output  1  instr_data/instr_pc hold a valid instruction for decode.
REQ-015 instr_data  output  INSTR_WIDTH  registered instruction.
REQ-016 instr_pc  output  PC_WIDTH  address of instr_data.
REQ-017 instr_ready  input  1  decode consumes instruction when instr_valid & instr_ready.
REQ-018 flush  output  1  registered one-cycle pulse: downstream SHALL discard in-flight work.
REQ-019 pc  output  PC_WIDTH  current fetch PC.

Function
REQ-020 FSM states: BOOT, RUN, REDIRECT; one-hot or binary at implementer's choice.
REQ-021 BOOT: entered on reset; imem_req=0; next cycle -> RUN unconditionally (absent taken redirect).
REQ-022 RUN: imem_req = ~instr_valid | instr_ready (output slot empty or draining this cycle).
REQ-023 Fetch accept = imem_req & imem_gnt: next cycle instr_data<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
REQ-024 Consume without accept (instr_valid & instr_ready & ~accept): instr_valid<=0.
REQ-025 Consume and accept same cycle: new instruction replaces old with no bubble; throughput 1 instr/cycle.
REQ-026 instr_valid & ~instr_ready: instr_data/instr_pc/instr_valid SHALL hold stable; imem_req=0.
REQ-027 pc increment SHALL wrap modulo 2^PC_WIDTH (0xFF+1 -> 0x00 at width 8), no flag.
REQ-028 Taken redirect = br_valid & pc_sel, in any state: next cycle pc<=br_target, instr_valid<=0, flush<=1, state<=REDIRECT.
REQ-029 Taken redirect SHALL take priority over a same-cycle fetch accept; accepted word discarded, pc not incremented.
REQ-030 br_valid & ~pc_sel SHALL have no effect on any state.
REQ-031 REDIRECT: imem_req=0 for exactly one cycle, then -> RUN; flush=0 unless another taken redirect arrives.
REQ-032 Taken redirect while in REDIRECT: latest br_target wins, flush pulses again, REDIRECT repeats one cycle.
REQ-033 flush SHALL be 0 in all cycles not immediately following a taken redirect.
REQ-034 imem_addr SHALL equal pc in every cycle; imem_gnt with imem_req=0 SHALL be ignored.
REQ-035 No combinational path from pc_sel/br_valid to imem_req, instr_valid or flush.

Reset
REQ-036 On rst=1 at a clock edge: state=BOOT, pc=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, flush=0.
REQ-037 rst SHALL override simultaneous taken redirect and fetch accept.
REQ-038 While rst=1 and in cycle after: imem_req=0.

Verification
REQ-039 Reset, imem_gnt=1, instr_ready=1 -> imem_req rises in the 2nd cycle after rst falls; instr_pc 0x00,0x01,0x02 on consecutive cycles.
REQ-040 instr_ready=0 for 3 cycles with instr_valid=1, instr_pc=0x05 -> outputs stable, imem_req=0, pc=0x06; release -> 0x06 fetched next.
REQ-041 Taken branch br_target=0x40 while accepting 0x10 -> flush=1 one cycle, instr_valid=0, pc=0x40, one bubble, next instr_pc=0x40.
REQ-042 br_valid=1, pc_sel=0 at pc=0x20 -> no flush, sequence continues 0x20,0x21.
REQ-043 pc=0xFF fetched -> next instr_pc=0x00.
REQ-044 Taken 0x30 then taken 0x50 next cycle -> two flush pulses, first fetch address 0x50; rst mid-redirect -> pc=RESET_PC, flush=0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the program counter, issues
//                single-cycle instruction-memory reads and presents one
//                registered instruction to decode with valid/ready handshake.
//                Taken redirects from execute reload the PC, drop the
//                in-flight word and pulse flush for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                    PC_WIDTH    = 8,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    // Branch resolution from execute
    input  logic                     br_valid,
    input  logic                     pc_sel,
    input  logic [PC_WIDTH-1:0]      br_target,
    // Instruction memory
    output logic                     imem_req,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic                     imem_gnt,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    // Decode interface
    output logic                     instr_valid,
    output logic [INSTR_WIDTH-1:0]   instr_data,
    output logic [PC_WIDTH-1:0]      instr_pc,
    input  logic                     instr_ready,
    // Pipeline control
    output logic                     flush,
    output logic [PC_WIDTH-1:0]      pc
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t                  state_q,       state_d;
    logic [PC_WIDTH-1:0]     pc_q,          pc_d;
    logic                    instr_valid_q, instr_valid_d;
    logic [INSTR_WIDTH-1:0]  instr_data_q,  instr_data_d;
    logic [PC_WIDTH-1:0]     instr_pc_q,    instr_pc_d;
    logic                    flush_q,       flush_d;

    logic                    req;
    logic                    accept;
    logic                    taken;

    // Request only in RUN when the output slot is empty or draining; rst
    // masks it so nothing is requested while reset is held.
    assign req    = (state_q == ST_RUN) & (~instr_valid_q | instr_ready) & ~rst;
    assign accept = req & imem_gnt;
    assign taken  = br_valid & pc_sel;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
            flush_q       <= flush_d;
        end
    end

    // Next-state logic: a taken redirect beats any same-cycle fetch accept
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;
        flush_d       = 1'b0;

        if (taken) begin
            state_d       = ST_REDIRECT;
            pc_d          = br_target;
            instr_valid_d = 1'b0;
            flush_d       = 1'b1;
        end else begin
            case (state_q)
                ST_BOOT:     state_d = ST_RUN;
                ST_RUN:      state_d = ST_RUN;
                ST_REDIRECT: state_d = ST_RUN;
                default:     state_d = ST_BOOT;
            endcase

            if (accept) begin
                // Load replaces any instruction being consumed: no bubble
                instr_data_d  = imem_rdata;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = pc_q + PC_WIDTH'(1);
            end else if (instr_valid_q && instr_ready) begin
                instr_valid_d = 1'b0;
            end
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;
    assign flush       = flush_q;

endmodule
`default_nettype wire
